resp_sig_checker: RTL

Response-side companion to the exhaustive combinational stimulus sequence: it accepts one {input vector, DUT response} pair per valid cycle, verifies that the input vectors arrive in exhaustive ascending order, and folds every pair into a multiple-input signature register (MISR). After all 2^VEC_W vectors it reports done and pass/fail against a golden signature. It sits between a stimulus source and the DUT outputs, so self-checking runs in simulation or on FPGA without a printing monitor.

---
 rtl/resp_sig_pkg.sv | 23 ++
 rtl/resp_misr.sv | 28 ++
 rtl/resp_sig_checker.sv | 98 +++++++++
 3 files changed

// File: rtl/resp_sig_pkg.sv
// Shared types and MISR arithmetic for resp_sig_checker; the bench reference model reuses misr_step.
package resp_sig_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic [15:0] DEFAULT_POLY = 16'h1021;
    localparam int          MAX_SIG_W    = 64;

    // One MISR step at width w (w <= MAX_SIG_W); callers zero-extend operands and truncate the result.
    function automatic logic [MAX_SIG_W-1:0] misr_step(
        input logic [MAX_SIG_W-1:0] sig,
        input logic [MAX_SIG_W-1:0] data,
        input logic [MAX_SIG_W-1:0] poly,
        input int                   w
    );
        logic [MAX_SIG_W-1:0] mask;
        logic [MAX_SIG_W-1:0] nxt;
        mask = (w >= MAX_SIG_W) ? '1 : ((64'd1 << w) - 64'd1);
        nxt  = (sig << 1) ^ (sig[6'(w - 1)] ? poly : '0) ^ data;
        return nxt & mask;
    endfunction

endpackage

// File: rtl/resp_misr.sv
// SIG_W-bit multiple-input signature register with synchronous clear and step enable.
module resp_misr
    import resp_sig_pkg::*;
#(
    parameter int               SIG_W = 16,
    parameter logic [SIG_W-1:0] POLY  = SIG_W'(DEFAULT_POLY)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic [SIG_W-1:0] data,
    output logic [SIG_W-1:0] sig,
    output logic [SIG_W-1:0] sig_next
);

    assign sig_next = SIG_W'(misr_step(MAX_SIG_W'(sig), MAX_SIG_W'(data), MAX_SIG_W'(POLY), SIG_W));

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            sig <= '0;
        end else if (en) begin
            sig <= sig_next;
        end
    end

endmodule

// File: rtl/resp_sig_checker.sv
// Checks exhaustive ascending stimulus order and signs {vec, resp} pairs into a MISR.
// Define RESP_SEQ_CHECK_EN to enable the ascending-order check; otherwise seq_err stays 0.
module resp_sig_checker
    import resp_sig_pkg::*;
#(
    parameter int               VEC_W   = 4,
    parameter int               RESP_W  = 3,
    parameter int               SIG_W   = 16,
    parameter logic [SIG_W-1:0] POLY    = SIG_W'(DEFAULT_POLY),
    parameter logic [SIG_W-1:0] EXP_SIG = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              vld,
    input  logic [VEC_W-1:0]  vec,
    input  logic [RESP_W-1:0] resp,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic              seq_err,
    output logic [SIG_W-1:0]  sig,
    output logic [VEC_W:0]    count
);

    localparam int             CNT_W = VEC_W + 1;
    localparam logic [CNT_W-1:0] LAST  = CNT_W'((1 << VEC_W) - 1);

    state_t           state;
    logic             accept;
    logic             take_start;
    logic             mismatch;
    logic             err_next;
    logic [SIG_W-1:0] sig_next;

    assign accept     = (state == RUN) && vld;
    assign take_start = (state != RUN) && start;

`ifdef RESP_SEQ_CHECK_EN
    assign mismatch = accept && (vec != count[VEC_W-1:0]);
`else
    assign mismatch = 1'b0;
`endif

    assign err_next = seq_err | mismatch;

    resp_misr #(
        .SIG_W (SIG_W),
        .POLY  (POLY)
    ) u_misr (
        .clk      (clk),
        .rst      (rst),
        .clr      (take_start),
        .en       (accept),
        .data     (SIG_W'({vec, resp})),
        .sig      (sig),
        .sig_next (sig_next)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            count   <= '0;
            seq_err <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            pass    <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state   <= RUN;
                        count   <= '0;
                        seq_err <= 1'b0;
                        busy    <= 1'b1;
                        done    <= 1'b0;
                        pass    <= 1'b0;
                    end
                end
                RUN: begin
                    if (vld) begin
                        count   <= count + CNT_W'(1);
                        seq_err <= err_next;
                        // The final pair's fold is evaluated here so pass appears with done.
                        if (count == LAST) begin
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            pass  <= (sig_next == EXP_SIG) && !err_next;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
